mips_mc_controller: RTL and testbench

MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

---
 rtl/mips_mc_controller.sv | 152 +++++++++++++++
 tb/tb_mips_mc_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT)
// with a bounded memory-wait counter and sticky illegal/timeout flags.
module mips_mc_controller #(
  parameter int ALU_OP_W    = 4,
  parameter int MAX_WAIT    = 15,
  parameter bit EN_REG_JUMP = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [5:0]          op_i,
  input  logic [5:0]          funct_i,
  input  logic                zero_i,
  input  logic                sign_i,
  input  logic                mem_ready_i,
  output logic [2:0]          state_o,
  output logic                pc_write_o,
  output logic                ir_write_o,
  output logic                reg_write_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic                iord_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [1:0]          alu_srca_o,
  output logic [1:0]          alu_srcb_o,
  output logic [1:0]          ext_op_o,
  output logic [1:0]          reg_dst_o,
  output logic [1:0]          wb_sel_o,
  output logic [1:0]          pc_src_o,
  output logic                illegal_o,
  output logic                timeout_o
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                         A_XOR = 4'd4, A_NOR = 4'd5, A_SLT = 4'd6, A_SLTU = 4'd7,
                         A_SLL = 4'd8, A_SRL = 4'd9, A_SRA = 4'd10;
  localparam int CW = $clog2(MAX_WAIT + 2);
  logic [2:0] state, nxt;
  logic [CW-1:0] cnt;
  logic [3:0] r_alu, i_alu;
  logic is_r, is_shift, is_ralu, is_jr, is_jalr, is_ialu, is_izext, is_lui;
  logic is_lw, is_sw, is_br, is_j, is_jal, legal, taken, waiting, expired;
  assign is_r     = op_i == 6'h00;
  assign is_shift = is_r && (funct_i == 6'h00 || funct_i == 6'h02 || funct_i == 6'h03);
  assign is_ralu  = is_shift || (is_r && (funct_i[5:3] == 3'b100 || funct_i == 6'h2A || funct_i == 6'h2B));
  assign is_jr    = EN_REG_JUMP && is_r && funct_i == 6'h08;
  assign is_jalr  = EN_REG_JUMP && is_r && funct_i == 6'h09;
  assign is_ialu  = op_i[5:3] == 3'b001 && op_i != 6'h0F;
  assign is_izext = op_i == 6'h0C || op_i == 6'h0D || op_i == 6'h0E;
  assign is_lui   = op_i == 6'h0F;
  assign is_lw    = op_i == 6'h23;
  assign is_sw    = op_i == 6'h2B;
  assign is_br    = op_i[5:2] == 4'b0001;
  assign is_j     = op_i == 6'h02;
  assign is_jal   = op_i == 6'h03;
  assign legal    = is_ralu || is_jr || is_jalr || is_ialu || is_lui || is_lw || is_sw || is_br || is_j || is_jal;
  // op[1:0] selects BEQ / BNE / BLEZ / BGTZ
  assign taken    = op_i[1] ? (op_i[0] ? !(zero_i || sign_i) : (zero_i || sign_i)) : (op_i[0] ^ zero_i);
  assign waiting  = (state == S_FETCH || state == S_MEM) && !mem_ready_i;
  assign expired  = cnt == CW'(MAX_WAIT);
  assign state_o  = state;
  assign i_alu = op_i == 6'h0A ? A_SLT : op_i == 6'h0B ? A_SLTU : op_i == 6'h0C ? A_AND :
                 op_i == 6'h0D ? A_OR : op_i == 6'h0E ? A_XOR : A_ADD;
  always_comb begin
    r_alu = A_ADD;
    case (funct_i)
      6'h22, 6'h23: r_alu = A_SUB;
      6'h24:        r_alu = A_AND;
      6'h25:        r_alu = A_OR;
      6'h26:        r_alu = A_XOR;
      6'h27:        r_alu = A_NOR;
      6'h2A:        r_alu = A_SLT;
      6'h2B:        r_alu = A_SLTU;
      6'h00:        r_alu = A_SLL;
      6'h02:        r_alu = A_SRL;
      6'h03:        r_alu = A_SRA;
      default:      r_alu = A_ADD;
    endcase
  end
  // all strobes stay low while reset is asserted, independent of the clock
  always_comb begin
    nxt = state;
    {pc_write_o, ir_write_o, reg_write_o, mem_req_o, mem_we_o, iord_o} = '0;
    alu_op_o = ALU_OP_W'(A_ADD);
    {alu_srca_o, alu_srcb_o, ext_op_o, reg_dst_o, wb_sel_o, pc_src_o} = '0;
    if (rst_n_i)
      case (state)
        S_FETCH: begin
          mem_req_o = 1'b1;
          if (mem_ready_i) begin
            {ir_write_o, pc_write_o} = 2'b11;
            alu_srcb_o = 2'd1;
            nxt = S_DECODE;
          end else if (expired) nxt = S_HALT;
        end
        S_DECODE: begin
          alu_srcb_o = 2'd3;
          if (is_j || is_jal) begin
            pc_write_o = 1'b1;
            pc_src_o = 2'd2;
            reg_write_o = is_jal;
            reg_dst_o = is_jal ? 2'd2 : 2'd0;
            wb_sel_o = is_jal ? 2'd3 : 2'd0;
            nxt = S_FETCH;
          end else if (is_jr || is_jalr) begin
            pc_write_o = 1'b1;
            pc_src_o = 2'd3;
            reg_write_o = is_jalr;
            reg_dst_o = is_jalr ? 2'd1 : 2'd0;
            wb_sel_o = is_jalr ? 2'd3 : 2'd0;
            nxt = S_FETCH;
          end else nxt = legal ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          alu_srca_o = is_lui ? 2'd0 : is_shift ? 2'd2 : 2'd1;
          alu_srcb_o = (is_ialu || is_lw || is_sw) ? 2'd2 : 2'd0;
          ext_op_o = is_lui ? 2'd3 : is_izext ? 2'd1 : 2'd0;
          alu_op_o = ALU_OP_W'(is_br ? A_SUB : is_ralu ? r_alu : is_ialu ? i_alu : A_ADD);
          pc_src_o = is_br ? 2'd1 : 2'd0;
          pc_write_o = is_br && taken;
          nxt = (is_lw || is_sw) ? S_MEM : (is_ralu || is_ialu || is_lui) ? S_WB : S_FETCH;
        end
        S_MEM: begin
          {mem_req_o, iord_o} = 2'b11;
          mem_we_o = is_sw;
          if (mem_ready_i) nxt = is_sw ? S_FETCH : S_WB;
          else if (expired) nxt = S_HALT;
        end
        S_WB: begin
          reg_write_o = 1'b1;
          reg_dst_o = is_r ? 2'd1 : 2'd0;
          wb_sel_o = is_lw ? 2'd1 : is_lui ? 2'd2 : 2'd0;
          ext_op_o = is_lui ? 2'd3 : 2'd0;
          nxt = S_FETCH;
        end
        S_HALT: nxt = S_HALT;
        default: nxt = S_FETCH;
      endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= S_FETCH;
      cnt <= '0;
      illegal_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? '0 : waiting ? cnt + 1'b1 : cnt;
      if (state == S_DECODE && nxt == S_HALT) illegal_o <= 1'b1;
      if ((state == S_FETCH || state == S_MEM) && nxt == S_HALT) timeout_o <= 1'b1;
    end
endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: instruction-level trace model of the multicycle controller
// compared cycle by cycle against the DUT, with directed and random instruction streams.
module tb_mips_mc_controller;
  localparam int MAX_WAIT = 15;
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
  localparam int K_R = 0, K_SH = 1, K_I = 2, K_IZ = 3, K_LUI = 4, K_LW = 5, K_SW = 6, K_BR = 7,
                 K_ILL = 8, K_J = 9, K_JAL = 10, K_JR = 11, K_JALR = 12;
  logic clk, rst_n, zero, sign, ready;
  logic [5:0] op, funct;
  logic [2:0] st, st0;
  logic pcw, irw, rw, mr, mwe, iord, ill, to;
  logic pcw0, irw0, rw0, mr0, mwe0, iord0, ill0, to0;
  logic [3:0] aop, aop0;
  logic [1:0] sa, sb, ext, dst, wbs, pcs, sa0, sb0, ext0, dst0, wbs0, pcs0;
  int checks = 0, errors = 0;

  mips_mc_controller #(.ALU_OP_W(4), .MAX_WAIT(MAX_WAIT), .EN_REG_JUMP(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .op_i(op), .funct_i(funct), .zero_i(zero), .sign_i(sign),
    .mem_ready_i(ready), .state_o(st), .pc_write_o(pcw), .ir_write_o(irw), .reg_write_o(rw),
    .mem_req_o(mr), .mem_we_o(mwe), .iord_o(iord), .alu_op_o(aop), .alu_srca_o(sa), .alu_srcb_o(sb),
    .ext_op_o(ext), .reg_dst_o(dst), .wb_sel_o(wbs), .pc_src_o(pcs), .illegal_o(ill), .timeout_o(to));

  mips_mc_controller #(.ALU_OP_W(4), .MAX_WAIT(MAX_WAIT), .EN_REG_JUMP(1'b0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .op_i(op), .funct_i(funct), .zero_i(zero), .sign_i(sign),
    .mem_ready_i(ready), .state_o(st0), .pc_write_o(pcw0), .ir_write_o(irw0), .reg_write_o(rw0),
    .mem_req_o(mr0), .mem_we_o(mwe0), .iord_o(iord0), .alu_op_o(aop0), .alu_srca_o(sa0), .alu_srcb_o(sb0),
    .ext_op_o(ext0), .reg_dst_o(dst0), .wb_sel_o(wbs0), .pc_src_o(pcs0), .illegal_o(ill0), .timeout_o(to0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int kind(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      if (f inside {6'h00, 6'h02, 6'h03}) return K_SH;
      if (f inside {[6'h20:6'h27], 6'h2A, 6'h2B}) return K_R;
      if (f == 6'h08) return K_JR;
      if (f == 6'h09) return K_JALR;
      return K_ILL;
    end
    if (o inside {[6'h08:6'h0B]}) return K_I;
    if (o inside {[6'h0C:6'h0E]}) return K_IZ;
    if (o == 6'h0F) return K_LUI;
    if (o == 6'h23) return K_LW;
    if (o == 6'h2B) return K_SW;
    if (o inside {[6'h04:6'h07]}) return K_BR;
    if (o == 6'h02) return K_J;
    if (o == 6'h03) return K_JAL;
    return K_ILL;
  endfunction

  // Entered and left in the low clock phase; fd/md are cycles without ready in FETCH/MEM.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input bit z, input bit s, input int fd, input int md);
    int k, e_pc, e_rw, e_mr, e_io, e_we, e_ir, e_dst, e_wb, e_sa, e_sb, e_ext, x_i;
    int n_pc, n_rw, n_mr, n_io, n_we, n_ir, g_dst, g_wb;
    bit mk, tk, h_ill, h_to;
    logic [2:0] exp[$];
    bit rdy[$];
    k = kind(o, f);
    mk = k == K_LW || k == K_SW;
    tk = o == 6'h04 ? z : o == 6'h05 ? !z : o == 6'h06 ? (z || s) : (!z && !s);
    h_to = fd > MAX_WAIT;
    h_ill = 1'b0;
    x_i = -1;
    for (int i = 0; i <= fd && i <= MAX_WAIT; i++) begin exp.push_back(S_FETCH); rdy.push_back(i == fd); end
    if (!h_to) begin
      exp.push_back(S_DECODE); rdy.push_back(1'b0);
      if (k == K_ILL) h_ill = 1'b1;
      else if (k < K_ILL) begin
        x_i = exp.size();
        exp.push_back(S_EXEC); rdy.push_back(1'b0);
        if (mk) for (int i = 0; i <= md; i++) begin exp.push_back(S_MEM); rdy.push_back(i == md); end
        if (k != K_SW && k != K_BR) begin exp.push_back(S_WB); rdy.push_back(1'b0); end
      end
    end
    e_ir = h_to ? 0 : 1;
    e_pc = h_to ? 0 : 1 + int'(k > K_ILL) + int'(k == K_BR && tk);
    e_rw = (!h_to && (k inside {K_R, K_SH, K_I, K_IZ, K_LUI, K_LW, K_JAL, K_JALR})) ? 1 : 0;
    e_mr = (h_to ? MAX_WAIT + 1 : fd + 1) + ((mk && !h_to) ? md + 1 : 0);
    e_io = (mk && !h_to) ? md + 1 : 0;
    e_we = (k == K_SW && !h_to) ? md + 1 : 0;
    e_dst = k == K_JAL ? 2 : (k inside {K_R, K_SH, K_JALR}) ? 1 : 0;
    e_wb = (k inside {K_JAL, K_JALR}) ? 3 : k == K_LW ? 1 : k == K_LUI ? 2 : 0;
    e_sa = k == K_SH ? 2 : k == K_LUI ? 0 : 1;
    e_sb = (k inside {K_I, K_IZ, K_LW, K_SW}) ? 2 : 0;
    e_ext = k == K_IZ ? 1 : k == K_LUI ? 3 : 0;
    {n_pc, n_rw, n_mr, n_io, n_we, n_ir} = '0;
    g_dst = -1; g_wb = -1;
    op = o; funct = f; zero = z; sign = s;
    for (int i = 0; i < exp.size(); i++) begin
      ready = (exp[i] == S_FETCH || exp[i] == S_MEM) ? rdy[i] : 1'($urandom);
      #1;
      checks++;
      if (st !== exp[i]) begin errors++; $display("FAIL seq op=%h f=%h cyc=%0d: state=%0d want %0d", o, f, i, st, exp[i]); end
      n_pc += int'(pcw); n_rw += int'(rw); n_mr += int'(mr); n_io += int'(iord); n_we += int'(mwe); n_ir += int'(irw);
      if (rw === 1'b1) begin g_dst = int'(dst); g_wb = int'(wbs); end
      if (exp[i] == S_DECODE) begin
        checks++;
        if ({sa, sb} !== 4'b0011) begin errors++; $display("FAIL decode_sel op=%h: srca=%0d srcb=%0d want 0/3", o, sa, sb); end
      end
      if (i == x_i) begin
        checks++;
        if (int'(sa) != e_sa || int'(sb) != e_sb || int'(ext) != e_ext)
          begin errors++; $display("FAIL exec_sel op=%h f=%h: srca/srcb/ext=%0d/%0d/%0d want %0d/%0d/%0d", o, f, sa, sb, ext, e_sa, e_sb, e_ext); end
        if (k == K_BR || mk) begin
          checks++;
          if (aop !== (k == K_BR ? 4'd1 : 4'd0)) begin errors++; $display("FAIL exec_alu op=%h: alu_op=%0d want %0d", o, aop, k == K_BR); end
        end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (st !== ((h_ill || h_to) ? S_HALT : S_FETCH) || ill !== h_ill || to !== h_to)
      begin errors++; $display("FAIL end op=%h f=%h: state=%0d ill=%b to=%b want %0d/%b/%b", o, f, st, ill, to, (h_ill || h_to) ? 5 : 0, h_ill, h_to); end
    checks++;
    if (n_pc != e_pc || n_ir != e_ir || n_rw != e_rw)
      begin errors++; $display("FAIL counts op=%h f=%h: pcw/irw/rw=%0d/%0d/%0d want %0d/%0d/%0d", o, f, n_pc, n_ir, n_rw, e_pc, e_ir, e_rw); end
    checks++;
    if (n_mr != e_mr || n_io != e_io || n_we != e_we)
      begin errors++; $display("FAIL mem_counts op=%h: req/iord/we=%0d/%0d/%0d want %0d/%0d/%0d", o, n_mr, n_io, n_we, e_mr, e_io, e_we); end
    if (e_rw == 1) begin
      checks++;
      if (g_dst != e_dst || g_wb != e_wb) begin errors++; $display("FAIL wb_sel op=%h f=%h: dst=%0d wb=%0d want %0d/%0d", o, f, g_dst, g_wb, e_dst, e_wb); end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready = 1'b1; op = 6'h23; #1;
    checks++;
    if (st !== S_FETCH || {pcw, irw, rw, mr, mwe, iord} !== 6'b0 || ill !== 1'b0 || to !== 1'b0)
      begin errors++; $display("FAIL reset_hold: state=%0d strobes=%b ill=%b to=%b want 0/000000/0/0", st, {pcw, irw, rw, mr, mwe, iord}, ill, to); end
    @(negedge clk);
    rst_n = 1'b1; ready = 1'b0; #1;
    checks++;
    if (st !== S_FETCH || mr !== 1'b1 || iord !== 1'b0) begin errors++; $display("FAIL reset_release: state=%0d req=%b iord=%b want 0/1/0", st, mr, iord); end
  endtask

  task automatic test_illegal();
    run_instr(6'h3F, 6'h00, 1'b0, 1'b0, 1, 0);
    repeat (4) begin
      ready = 1'($urandom); zero = 1'($urandom); op = 6'($urandom);
      @(negedge clk); #1;
      checks++;
      if (st !== S_HALT || ill !== 1'b1 || {pcw, irw, rw, mr, mwe, iord} !== 6'b0)
        begin errors++; $display("FAIL halt_hold: state=%0d ill=%b strobes=%b want 5/1/000000", st, ill, {pcw, irw, rw, mr, mwe, iord}); end
    end
    rst_n = 1'b0; #1;
    checks++;
    if (st !== S_FETCH || ill !== 1'b0) begin errors++; $display("FAIL halt_reset: state=%0d ill=%b want 0/0", st, ill); end
    @(negedge clk);
    rst_n = 1'b1; ready = 1'b0; #1;
  endtask

  task automatic test_no_reg_jump();
    do_reset();
    op = 6'h00; funct = 6'h08; ready = 1'b1; #1;
    checks++;
    if (st0 !== S_FETCH) begin errors++; $display("FAIL nrj_fetch: state=%0d want 0", st0); end
    @(negedge clk); ready = 1'b0; #1;
    checks++;
    if (st0 !== S_DECODE) begin errors++; $display("FAIL nrj_decode: state=%0d want 1", st0); end
    @(negedge clk); #1;
    checks++;
    if (st0 !== S_HALT || ill0 !== 1'b1 || st !== S_FETCH || ill !== 1'b0)
      begin errors++; $display("FAIL nrj_halt: dut0 state=%0d ill=%b, dut state=%0d ill=%b want 5/1 0/0", st0, ill0, st, ill); end
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if (st0 !== S_HALT || ill0 !== 1'b1) begin errors++; $display("FAIL nrj_hold: state=%0d ill=%b want 5/1", st0, ill0); end
    end
    do_reset();
    checks++;
    if (st0 !== S_FETCH || ill0 !== 1'b0) begin errors++; $display("FAIL nrj_reset: state=%0d ill=%b want 0/0", st0, ill0); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    op = 6'h23; funct = 6'h00; ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (st !== S_MEM || mr !== 1'b1 || iord !== 1'b1) begin errors++; $display("FAIL midop_mem: state=%0d req=%b iord=%b want 3/1/1", st, mr, iord); end
    rst_n = 1'b0; #1;
    checks++;
    if (st !== S_FETCH || {pcw, irw, rw, mr, mwe, iord} !== 6'b0) begin errors++; $display("FAIL midop_abort: state=%0d strobes=%b want 0/000000", st, {pcw, irw, rw, mr, mwe, iord}); end
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (st !== S_FETCH || {pcw, irw, rw, mr, mwe, iord} !== 6'b0) begin errors++; $display("FAIL midop_held: state=%0d strobes=%b want 0/000000", st, {pcw, irw, rw, mr, mwe, iord}); end
    rst_n = 1'b1; #1;
    checks++;
    if (st !== S_FETCH || mr !== 1'b1) begin errors++; $display("FAIL midop_release: state=%0d req=%b want 0/1", st, mr); end
  endtask

  task automatic test_random();
    logic [5:0] rf[16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h01};
    logic [5:0] io[20] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B,
                           6'h04, 6'h05, 6'h06, 6'h07, 6'h02, 6'h03, 6'h23, 6'h2B, 6'h3F, 6'h1C};
    logic [5:0] o, f;
    int fd;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 4) begin o = 6'h00; f = rf[$urandom_range(0, 15)]; end
      else begin o = io[$urandom_range(0, 19)]; f = 6'($urandom); end
      fd = ($urandom_range(0, 19) == 0) ? MAX_WAIT + 1 : $urandom_range(0, 4);
      run_instr(o, f, 1'($urandom), 1'($urandom), fd, $urandom_range(0, 4));
      if (kind(o, f) == K_ILL || fd > MAX_WAIT) do_reset();
    end
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; sign = 1'b0;
    @(negedge clk);
    test_reset();
    run_instr(6'h00, 6'h21, 1'b0, 1'b0, 0, 0);
    run_instr(6'h23, 6'h00, 1'b0, 1'b0, 0, 3);
    run_instr(6'h04, 6'h00, 1'b1, 1'b0, 0, 0);
    run_instr(6'h05, 6'h00, 1'b1, 1'b0, 0, 0);
    run_instr(6'h03, 6'h00, 1'b0, 1'b0, 0, 0);
    run_instr(6'h2B, 6'h00, 1'b0, 1'b0, 2, 1);
    run_instr(6'h0F, 6'h00, 1'b0, 1'b0, 1, 0);
    run_instr(6'h00, 6'h09, 1'b0, 1'b0, 0, 0);
    test_illegal();
    test_no_reg_jump();
    do_reset();
    run_instr(6'h00, 6'h21, 1'b0, 1'b0, MAX_WAIT + 1, 0);
    do_reset();
    run_instr(6'h00, 6'h21, 1'b0, 1'b0, MAX_WAIT, 0);
    run_instr(6'h23, 6'h00, 1'b0, 1'b0, 0, MAX_WAIT);
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
